multicycle_ctrl: RTL

Multi-cycle control FSM for the integer core: sequences instruction fetch, decode, ALU execute, store and register write-back for ADDI, SW and R-type ADD/SUB. It sits beside the datapath, decodes the IR fields and drives the ALU's 4-bit `alu_ctrl` plus all datapath/memory strobes. It shares a single memory port between fetch and store through a req/ready handshake, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for ADDI / SW / ADD / SUB: sequences fetch, decode,
// execute, store and write-back over one shared req/ready memory port.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_ALU_CTRL = 4'b1111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        alu_src_b,
  output logic        imm_sel,
  output logic [3:0]  alu_ctrl,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] C_I    = 2'd0;
  localparam logic [1:0] C_S    = 2'd1;
  localparam logic [1:0] C_RADD = 2'd2;
  localparam logic [1:0] C_RSUB = 2'd3;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [3:0] ALU_SUB = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;

  logic [2:0]  state_q,   state_d;
  logic [1:0]  cls_q,     cls_d;
  logic        run_q,     run_d;
  logic [31:0] instret_q, instret_d;

  // Next-state, class capture and retire counting.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    cls_d     = cls_q;
    instret_d = instret_q;
    run_d     = 1'b1;
    case (state_q)
      S_FETCH: begin
        if (run_q && mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXEC;
        if (opcode == OP_IMM && funct3 == 3'b000)
          cls_d = C_I;
        else if (opcode == OP_STORE && funct3 == 3'b010)
          cls_d = C_S;
        else if (opcode == OP_REG && funct3 == 3'b000)
          cls_d = funct7b5 ? C_RSUB : C_RADD;
        else
          state_d = S_HALT;
      end
      S_EXEC: begin
        state_d = (cls_q == C_S) ? S_MEM : S_WB;
      end
      S_WB: begin
        state_d   = S_FETCH;
        instret_d = instret_q + 32'd1;
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d   = S_FETCH;
          instret_d = instret_q + 32'd1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // run_q holds off the first fetch until the first edge after reset release,
  // so every output is quiet while rst_n is low regardless of mem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from pre-edge values.
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= C_I;
      run_q     <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      run_q     <= run_d;
      instret_q <= instret_d;
    end
  end

  // Moore outputs, apart from the fetch strobes that qualify on mem_ready.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    alu_src_b = 1'b0;
    imm_sel   = 1'b0;
    illegal   = 1'b0;
    alu_ctrl  = RESET_ALU_CTRL;
    case (state_q)
      S_FETCH: begin
        mem_req = run_q;
        ir_we   = run_q && mem_ready;
        pc_we   = run_q && mem_ready;
      end
      S_EXEC, S_WB, S_MEM: begin
        alu_ctrl  = (cls_q == C_RSUB) ? ALU_SUB : ALU_ADD;
        alu_src_b = (cls_q == C_I) || (cls_q == C_S);
        imm_sel   = (cls_q == C_S);
        if (state_q == S_WB) reg_we = 1'b1;
        if (state_q == S_MEM) begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
        end
      end
      S_HALT:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign instret = instret_q;

endmodule
